// File: rtl/la_presetgen_pkg.sv
// Shared definitions for the preset sequencer.
//   state_t    : sequencer state encoding (IDLE / ASSERT / RELEASE)
//   clog2_min1 : counter width helper, never returns less than 1 bit
package la_presetgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Smallest w >= 1 with 2**w >= v. A zero-width counter is never useful,
  // so STAGGER=0 still gets a 1-bit (idle) timer.
  function automatic int clog2_min1(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/la_presetgen_cnt.sv
// Terminal-count timer used for both the hold and the stagger intervals.
// Ports:
//   i_clk    : clock, rising edge
//   i_nreset : synchronous active-low reset (count -> 0)
//   i_load   : restart the count from 0 (issued on every state change)
//   i_en     : advance the count while set
//   o_tc     : count has reached TERM; the count saturates there
module la_presetgen_cnt #(
  parameter int W    = 2,
  parameter int TERM = 1
) (
  input  logic i_clk,
  input  logic i_nreset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_cnt;

  assign o_tc = (r_cnt == W'(TERM));

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/la_presetgen.sv
// Preset sequencer: drives the active-low nset pins of N flop banks low
// together, holds them for HOLD cycles, then releases them one slot at a
// time STAGGER cycles apart. Runs after reset; software re-runs it on a
// subset with a one-cycle req.
// Ports:
//   clk    : clock, rising edge
//   nreset : synchronous active-low reset (restarts a full sequence)
//   req    : one-cycle soft sequence request, accepted only when idle
//   sel    : participation mask, sampled with an accepted req
//   nset   : active-low preset outputs, bit i released in slot i
//   busy   : sequence in progress
//   done   : one-cycle pulse on the cycle after completion
module la_presetgen
  import la_presetgen_pkg::*;
#(
  parameter int N       = 4,
  parameter int HOLD    = 8,
  parameter int STAGGER = 2,
  parameter     PROP    = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         req,
  input  logic [N-1:0] sel,
  output logic [N-1:0] nset,
  output logic         busy,
  output logic         done
);

  localparam int HOLD_W = clog2_min1(HOLD + 1);
  localparam int STG_W  = clog2_min1(STAGGER + 1);
  localparam int IDX_W  = clog2_min1(N + 1);
  // Timers terminate one count early: the releasing edge is the one that
  // sees the terminal count, so a HOLD of 1 releases on the next edge.
  localparam int STG_TERM = (STAGGER > 0) ? STAGGER - 1 : 0;
  // All slots collapse onto the hold edge when there is nothing to stagger.
  localparam bit ONE_SHOT = (N == 1) || (STAGGER == 0);

  state_t           r_state, w_state_next;
  logic [N-1:0]     r_nset, w_nset_next;
  logic [N-1:0]     r_sel, w_sel_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             w_hold_load, w_stg_load;
  logic             w_hold_tc, w_stg_tc;
  logic [N-1:0]     w_slot_mask;

  // One-hot decode of the slot being released.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      assign w_slot_mask[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  la_presetgen_cnt #(.W(HOLD_W), .TERM(HOLD - 1)) u_hold (
    .i_clk    (clk),
    .i_nreset (nreset),
    .i_load   (w_hold_load),
    .i_en     (r_state == ST_ASSERT),
    .o_tc     (w_hold_tc)
  );

  la_presetgen_cnt #(.W(STG_W), .TERM(STG_TERM)) u_stagger (
    .i_clk    (clk),
    .i_nreset (nreset),
    .i_load   (w_stg_load),
    .i_en     (r_state == ST_RELEASE),
    .o_tc     (w_stg_tc)
  );

  always_comb begin
    w_state_next = r_state;
    w_nset_next  = r_nset;
    w_sel_next   = r_sel;
    w_idx_next   = r_idx;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_hold_load  = 1'b0;
    w_stg_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_state_next = ST_ASSERT;
          w_sel_next   = sel;
          w_nset_next  = ~sel;
          w_busy_next  = 1'b1;
          w_hold_load  = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (w_hold_tc) begin
          if (ONE_SHOT) begin
            w_nset_next  = r_nset | r_sel;
            w_state_next = ST_IDLE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            // r_idx is 0 here, so the decode selects slot 0.
            w_nset_next  = r_nset | (r_sel & w_slot_mask);
            w_idx_next   = IDX_W'(1);
            w_stg_load   = 1'b1;
            w_state_next = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (w_stg_tc) begin
          // Unselected slots still consume their time slot.
          w_nset_next = r_nset | (r_sel & w_slot_mask);
          if (r_idx == IDX_W'(N - 1)) begin
            w_state_next = ST_IDLE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
            w_stg_load = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= ST_ASSERT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_nset <= '0;
      r_sel  <= '1;
      r_idx  <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_nset <= w_nset_next;
      r_sel  <= w_sel_next;
      r_idx  <= w_idx_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
    end
  end

  assign nset = r_nset;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_la_presetgen.sv
module tb_la_presetgen;

  logic       clk;
  logic       nreset;
  logic       req;
  logic [3:0] sel;
  logic [3:0] nset_a, nset_z;
  logic       busy_a, busy_z, done_a, done_z;

  int checks = 0;
  int passed = 0;

  la_presetgen #(.N(4), .HOLD(3), .STAGGER(2), .PROP("DEFAULT")) dut (
    .clk    (clk),
    .nreset (nreset),
    .req    (req),
    .sel    (sel),
    .nset   (nset_a),
    .busy   (busy_a),
    .done   (done_a)
  );

  la_presetgen #(.N(4), .HOLD(3), .STAGGER(0), .PROP("DEFAULT")) dut_s0 (
    .clk    (clk),
    .nreset (nreset),
    .req    (req),
    .sel    (sel),
    .nset   (nset_z),
    .busy   (busy_z),
    .done   (done_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset release: R is the last reset edge; bit i rises after R+3+2i.
  task automatic test_reset;
    logic [3:0] exp_n [0:10];
    logic       eb, ed;
    exp_n = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0011,
              4'b0011, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
    nreset = 1'b0; req = 1'b0; sel = 4'b0000;
    tick; tick;
    nreset = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick;
      eb = (k < 9);
      ed = (k == 9);
      checks++;
      if (nset_a !== exp_n[k]) $display("FAIL reset_nset k=%0d got %b want %b", k, nset_a, exp_n[k]);
      else passed++;
      checks++;
      if (busy_a !== eb) $display("FAIL reset_busy k=%0d got %b want %b", k, busy_a, eb);
      else passed++;
      checks++;
      if (done_a !== ed) $display("FAIL reset_done k=%0d got %b want %b", k, done_a, ed);
      else passed++;
      if (k == 2 || k == 3) begin
        checks++;
        if (nset_z !== ((k == 3) ? 4'b1111 : 4'b0000))
          $display("FAIL reset_s0_nset k=%0d got %b", k, nset_z);
        else passed++;
        checks++;
        if (done_z !== (k == 3)) $display("FAIL reset_s0_done k=%0d got %b want %b", k, done_z, (k == 3));
        else passed++;
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_soft_mask;
    logic [3:0] exp_n [0:10];
    logic       eb, ed;
    exp_n = '{4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1011, 4'b1011,
              4'b1011, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    req = 1'b1; sel = 4'b0101;
    tick;
    req = 1'b0; sel = 4'b0000;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick;
      eb = (k < 9);
      ed = (k == 9);
      checks++;
      if (nset_a !== exp_n[k]) $display("FAIL soft_nset k=%0d got %b want %b", k, nset_a, exp_n[k]);
      else passed++;
      checks++;
      if (busy_a !== eb) $display("FAIL soft_busy k=%0d got %b want %b", k, busy_a, eb);
      else passed++;
      checks++;
      if (done_a !== ed) $display("FAIL soft_done k=%0d got %b want %b", k, done_a, ed);
      else passed++;
    end
    $display("test_soft_mask done");
  endtask

  task automatic test_ignored_req;
    logic [3:0] exp_n [0:10];
    logic       eb, ed;
    exp_n = '{4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1011, 4'b1011,
              4'b1011, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    req = 1'b1; sel = 4'b0101;
    tick;
    req = 1'b0; sel = 4'b0000;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick;
      if (k == 4) begin
        req = 1'b0; sel = 4'b0000;
      end
      eb = (k < 9);
      ed = (k == 9);
      checks++;
      if (nset_a !== exp_n[k]) $display("FAIL ignored_nset k=%0d got %b want %b", k, nset_a, exp_n[k]);
      else passed++;
      checks++;
      if (busy_a !== eb) $display("FAIL ignored_busy k=%0d got %b want %b", k, busy_a, eb);
      else passed++;
      checks++;
      if (done_a !== ed) $display("FAIL ignored_done k=%0d got %b want %b", k, done_a, ed);
      else passed++;
      if (k == 3) begin
        req = 1'b1; sel = 4'b1111;  // sampled at R+4 while busy
      end
    end
    for (int k = 11; k <= 12; k++) begin
      tick;
      checks++;
      if (nset_a !== 4'b1111 || busy_a !== 1'b0 || done_a !== 1'b0)
        $display("FAIL ignored_after k=%0d got nset=%b busy=%b done=%b want 1111/0/0", k, nset_a, busy_a, done_a);
      else passed++;
    end
    $display("test_ignored_req done");
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp_n [0:10];
    logic       eb, ed;
    exp_n = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0011,
              4'b0011, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
    req = 1'b1; sel = 4'b0010;
    tick;
    req = 1'b0; sel = 4'b0000;
    tick; tick; tick; tick;
    checks++;
    if (nset_a !== 4'b1101 || busy_a !== 1'b1)
      $display("FAIL mid_before got nset=%b busy=%b want 1101/1", nset_a, busy_a);
    else passed++;
    nreset = 1'b0;
    tick;
    checks++;
    if (nset_a !== 4'b0000 || busy_a !== 1'b1 || done_a !== 1'b0)
      $display("FAIL mid_reset got nset=%b busy=%b done=%b want 0000/1/0", nset_a, busy_a, done_a);
    else passed++;
    nreset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick;
      eb = (k < 9);
      ed = (k == 9);
      checks++;
      if (nset_a !== exp_n[k]) $display("FAIL mid_nset k=%0d got %b want %b", k, nset_a, exp_n[k]);
      else passed++;
      checks++;
      if (busy_a !== eb || done_a !== ed)
        $display("FAIL mid_flags k=%0d got busy=%b done=%b want %b/%b", k, busy_a, done_a, eb, ed);
      else passed++;
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_stagger0;
    logic [3:0] en;
    req = 1'b1; sel = 4'b1111;
    tick;
    req = 1'b0; sel = 4'b0000;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick;
      en = (k >= 3) ? 4'b1111 : 4'b0000;
      checks++;
      if (nset_z !== en) $display("FAIL s0_nset k=%0d got %b want %b", k, nset_z, en);
      else passed++;
      checks++;
      if (busy_z !== (k < 3) || done_z !== (k == 3))
        $display("FAIL s0_flags k=%0d got busy=%b done=%b want %b/%b", k, busy_z, done_z, (k < 3), (k == 3));
      else passed++;
      if (k == 3) begin
        checks++;
        if (nset_a !== 4'b0001) $display("FAIL s0_ref_nset got %b want 0001", nset_a);
        else passed++;
      end
    end
    for (int k = 5; k <= 10; k++) tick;
    $display("test_stagger0 done");
  endtask

  task automatic test_sel_zero;
    req = 1'b1; sel = 4'b0000;
    tick;
    req = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick;
      checks++;
      if (nset_a !== 4'b1111) $display("FAIL zero_nset k=%0d got %b want 1111", k, nset_a);
      else passed++;
      checks++;
      if (busy_a !== (k < 9) || done_a !== (k == 9))
        $display("FAIL zero_flags k=%0d got busy=%b done=%b want %b/%b", k, busy_a, done_a, (k < 9), (k == 9));
      else passed++;
    end
    $display("test_sel_zero done");
  endtask

  // req held across the done edge (ignored) and the next idle edge (taken).
  task automatic test_back_to_back;
    req = 1'b1; sel = 4'b0011;
    tick;
    req = 1'b0; sel = 4'b0000;
    for (int k = 1; k <= 8; k++) tick;
    req = 1'b1; sel = 4'b1100;
    tick;  // R+9
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || nset_a !== 4'b1111)
      $display("FAIL b2b_done_edge got done=%b busy=%b nset=%b want 1/0/1111", done_a, busy_a, nset_a);
    else passed++;
    tick;  // R+10, new R
    req = 1'b0; sel = 4'b0000;
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1 || nset_a !== 4'b0011)
      $display("FAIL b2b_accept got done=%b busy=%b nset=%b want 0/1/0011", done_a, busy_a, nset_a);
    else passed++;
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k == 7) begin
        checks++;
        if (nset_a !== 4'b0111) $display("FAIL b2b_slot2 got %b want 0111", nset_a);
        else passed++;
      end
    end
    checks++;
    if (done_a !== 1'b1 || nset_a !== 4'b1111)
      $display("FAIL b2b_second_done got done=%b nset=%b want 1/1111", done_a, nset_a);
    else passed++;
    tick;
    $display("test_back_to_back done");
  endtask

  initial begin
    nreset = 1'b0;
    req    = 1'b0;
    sel    = 4'b0000;
    test_reset();
    test_soft_mask();
    test_ignored_req();
    test_reset_mid();
    test_stagger0();
    test_sel_zero();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
